// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit types, digit bounds and load-value coercion.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef logic [15:0] bcd4_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_counter_4dig_if.sv
// bcd_counter_4dig_if: control/status bundle of the 4-digit BCD counter.
// load/load_val exist only when BCD_LOAD_EN is defined.
interface bcd_counter_4dig_if;
  import bcd_pkg::*;
  logic clk10Hz, en, up, clr;
`ifdef BCD_LOAD_EN
  logic load;
  bcd4_t load_val;
`endif
  bcd4_t count;
  logic tc, wrap;
`ifdef BCD_LOAD_EN
  modport master(output clk10Hz, en, up, clr, load, load_val, input count, tc, wrap);
  modport slave(input clk10Hz, en, up, clr, load, load_val, output count, tc, wrap);
`else
  modport master(output clk10Hz, en, up, clr, input count, tc, wrap);
  modport slave(input clk10Hz, en, up, clr, output count, tc, wrap);
`endif
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade with clear, saturating load and up/down step; co flags carry/borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clkFPGA,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       co
);
  assign co = step & (up ? q == BCD_MAX : q == BCD_ZERO);
  always_ff @(posedge clkFPGA or posedge rst)
    if (rst) q <= BCD_ZERO;
    else if (clr) q <= BCD_ZERO;
    else if (ld) q <= bcd_sat(ld_val);
    else if (step) q <= up ? (q == BCD_MAX ? BCD_ZERO : q + 4'd1) : (q == BCD_ZERO ? BCD_MAX : q - 4'd1);
endmodule

// File: rtl/bcd_counter_4dig.sv
// bcd_counter_4dig: 4-digit up/down BCD counter stepped by rising edges of clk10Hz.
// Optional parallel load with BCD_LOAD_EN; WRAP selects rollover (1) or saturation (0).
module bcd_counter_4dig
  import bcd_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input logic clkFPGA,
  input logic rst,
  bcd_counter_4dig_if.slave bus
);
  logic clk10Hz_d, wrap_q, tick, at_bound, step_go, ld;
  bcd4_t ld_val, cnt;
  logic [3:0] st, co;
`ifdef BCD_LOAD_EN
  assign ld = bus.load;
  assign ld_val = bus.load_val;
`else
  assign ld = 1'b0;
  assign ld_val = '0;
`endif
  assign tick = bus.clk10Hz & ~clk10Hz_d;
  assign at_bound = bus.up ? cnt == {4{BCD_MAX}} : cnt == {4{BCD_ZERO}};
  // saturation simply suppresses the step at the bound, so co[3] can only fire on a true rollover
  assign step_go = tick & bus.en & ~bus.clr & ~ld & (WRAP | ~at_bound);
  assign st = {co[2:0], step_go};
  for (genvar g = 0; g < 4; g++) begin : dig
    bcd_digit u_digit (
      .clkFPGA(clkFPGA),
      .rst(rst),
      .step(st[g]),
      .up(bus.up),
      .clr(bus.clr),
      .ld(ld),
      .ld_val(ld_val[4*g+:4]),
      .q(cnt[4*g+:4]),
      .co(co[g])
    );
  end
  always_ff @(posedge clkFPGA or posedge rst)
    if (rst) begin
      clk10Hz_d <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      clk10Hz_d <= bus.clk10Hz;
      wrap_q <= co[3];
    end
  assign bus.count = cnt;
  assign bus.tc = at_bound;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_bcd_counter_4dig.sv
// tb_bcd_counter_4dig: directed plus random stimulus on a rollover (WRAP=1) and a saturating (WRAP=0)
// instance driven in lockstep, checked against a decimal-integer reference model.
module tb_bcd_counter_4dig;
  logic clkFPGA = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  int m1 = 0, m0 = 0;
  bit prev10 = 1'b1, w1 = 1'b0, w0 = 1'b0;
  bit c10 = 1'b1;
  bcd_counter_4dig_if b1 ();
  bcd_counter_4dig_if b0 ();
  bcd_counter_4dig #(.WRAP(1'b1)) u1 (.clkFPGA(clkFPGA), .rst(rst), .bus(b1));
  bcd_counter_4dig #(.WRAP(1'b0)) u0 (.clkFPGA(clkFPGA), .rst(rst), .bus(b0));
  always #5 clkFPGA = ~clkFPGA;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic int sat_val(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + ((v[4*i+:4] > 4'd9) ? 9 : int'(v[4*i+:4]));
    return r;
  endfunction

  task automatic mstep(inout int m, input bit u, input bit wr, output bit w);
    w = 1'b0;
    if (u) begin
      if (m < 9999) m++;
      else if (wr) begin m = 0; w = 1'b1; end
    end else begin
      if (m > 0) m--;
      else if (wr) begin m = 9999; w = 1'b1; end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input bit u);
    chk("count_w1", b1.count, to_bcd(m1));
    chk("count_w0", b0.count, to_bcd(m0));
    chk("wrap_w1", 16'(b1.wrap), 16'(w1));
    chk("wrap_w0", 16'(b0.wrap), 16'(w0));
    chk("tc_w1", 16'(b1.tc), 16'(u ? m1 == 9999 : m1 == 0));
    chk("tc_w0", 16'(b0.tc), 16'(u ? m0 == 9999 : m0 == 0));
  endtask

  // drive one clkFPGA cycle of inputs, update the model, then check a cycle later
  task automatic cyc(input bit c, input bit e, input bit u, input bit cl, input bit l, input logic [15:0] lv);
    bit rise = c && !prev10;
    b1.clk10Hz = c; b1.en = e; b1.up = u; b1.clr = cl;
    b0.clk10Hz = c; b0.en = e; b0.up = u; b0.clr = cl;
`ifdef BCD_LOAD_EN
    b1.load = l; b1.load_val = lv;
    b0.load = l; b0.load_val = lv;
`endif
    w1 = 1'b0; w0 = 1'b0;
    if (cl) begin m1 = 0; m0 = 0; end
    else if (l) begin m1 = sat_val(lv); m0 = m1; end
    else if (rise && e) begin mstep(m1, u, 1'b1, w1); mstep(m0, u, 1'b0, w0); end
    prev10 = c;
    c10 = c;
    @(negedge clkFPGA);
    check_all(u);
  endtask

  task automatic periods(input int n, input bit e, input bit u);
    for (int i = 0; i < n; i++) begin
      cyc(1, e, u, 0, 0, 0); cyc(1, e, u, 0, 0, 0);
      cyc(0, e, u, 0, 0, 0); cyc(0, e, u, 0, 0, 0);
    end
  endtask

  initial begin
    b1.clk10Hz = 1; b1.en = 1; b1.up = 1; b1.clr = 0;
    b0.clk10Hz = 1; b0.en = 1; b0.up = 1; b0.clr = 0;
`ifdef BCD_LOAD_EN
    b1.load = 0; b1.load_val = '0; b0.load = 0; b0.load_val = '0;
`endif
    repeat (2) @(negedge clkFPGA);
    check_all(1);
    rst = 0;
    // clk10Hz already high at release: no step until it falls and rises again
    repeat (3) cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("first_tick", b1.count, 16'h0001);
    cyc(0, 1, 1, 1, 0, 0);
    periods(12, 1, 1);
    chk("twelve", b1.count, 16'h0012);
`ifdef BCD_LOAD_EN
    cyc(0, 1, 1, 0, 1, 16'h0998);
    periods(2, 1, 1);
    chk("to_1000", b1.count, 16'h1000);
    cyc(0, 1, 1, 0, 1, 16'h9999);
    cyc(1, 1, 1, 0, 0, 0);
    chk("roll_w1", b1.count, 16'h0000);
    chk("roll_pulse", 16'(b1.wrap), 16'h1);
    chk("sat_w0", b0.count, 16'h9999);
    cyc(1, 1, 1, 0, 0, 0);
    chk("pulse_end", 16'(b1.wrap), 16'h0);
    cyc(0, 1, 1, 0, 1, 16'hA3F5);
    chk("coerce", b1.count, 16'h9395);
    cyc(0, 1, 1, 0, 1, 16'h0500);
    cyc(1, 1, 1, 1, 0, 0);
    chk("clr_tick", b1.count, 16'h0000);
    cyc(1, 1, 1, 0, 1, 16'h0042);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 16'h1234);
    chk("load_tick", b1.count, 16'h1234);
`else
    cyc(1, 1, 1, 1, 0, 0);
    chk("clr_tick", b1.count, 16'h0000);
`endif
    cyc(0, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("under_w1", b1.count, 16'h9999);
    chk("under_pulse", 16'(b1.wrap), 16'h1);
    chk("under_w0", b0.count, 16'h0000);
    chk("under_tc", 16'(b0.tc), 16'h1);
    cyc(0, 1, 1, 1, 0, 0);
    periods(42, 1, 1);
    periods(5, 0, 1);
    chk("hold42", b1.count, 16'h0042);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("reenable", b1.count, 16'h0042);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("after_re", b1.count, 16'h0043);
    for (int i = 0; i < 1500; i++) begin
      bit c = ($urandom_range(0, 2) == 0) ? !c10 : c10;
      bit l = 1'b0;
      logic [15:0] lv = 16'($urandom);
`ifdef BCD_LOAD_EN
      l = $urandom_range(0, 29) == 0;
`endif
      cyc(c, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0, l, lv);
    end
    // asynchronous reset between clock edges
    #2 rst = 1;
    #1;
    m1 = 0; m0 = 0; w1 = 0; w0 = 0;
    chk("async_w1", b1.count, 16'h0000);
    chk("async_w0", b0.count, 16'h0000);
    @(negedge clkFPGA);
    rst = 0;
    prev10 = 1'b1;
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("post_rst", b1.count, 16'h0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_counter_4dig.md
# bcd_counter_4dig

Four-digit decimal (BCD) counter that consumes the 10 Hz square wave from the frequency divider and advances once per rising edge of that wave. It runs entirely in the `clkFPGA` domain: `clk10Hz` is sampled as a data level, not used as a clock. It supports up/down counting, hold, synchronous clear and parallel load. Its packed BCD output feeds the display-multiplexing stage.

## Interface
- `WRAP`, default 1: 1 = roll over at the count bounds; 0 = saturate at the bounds.
- `clkFPGA`  in  1  system clock, the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `clk10Hz`  in  1  10 Hz level from the divider, synchronous to `clkFPGA`.
- `en`  in  1  count enable; when 0, ticks are ignored.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `clr`  in  1  synchronous clear to 0000.
- `load`  in  1  synchronous parallel load (present only with `BCD_LOAD_EN`).
- `load_val`  in  16  packed BCD load value, `[15:12]` = thousands (present only with `BCD_LOAD_EN`).
- `count`  out  16  packed BCD count, `[15:12]` thousands … `[3:0]` units.
- `tc`  out  1  terminal count: `count`=9999 when `up`=1; `count`=0000 when `up`=0. Combinational from `count` and `up`.
- `wrap`  out  1  one-cycle pulse on each rollover.

## Operation
- Edge detect: register `clk10Hz_d` holds the previous sample. `tick = clk10Hz & ~clk10Hz_d`.
- Per-clock update priority: `rst` > `clr` > `load` > (`tick & en`) step > hold.
- Step up: the units digit increments. A digit at 9 becomes 0 and carries into the next digit, chained over all four digits.
- Step down: the units digit decrements. A digit at 0 becomes 9 and borrows from the next digit.
- Up from 9999, `WRAP`=1: count becomes 0000 and `wrap`=1 for one cycle. Down from 0000, `WRAP`=1: count becomes 9999 and `wrap`=1 for one cycle.
- `WRAP`=0: at 9999 going up, or 0000 going down, the count holds and `wrap` is never asserted.
- Load: any `load_val` digit greater than 9 is coerced to 9. No `wrap` is generated on a load.
- `clr` or `load` in the same cycle as a tick: the tick is discarded, not deferred.
- `en` low: `clk10Hz_d` keeps tracking `clk10Hz`, so re-enabling does not produce a stale tick.
- `up` may change at any time. It takes effect on the next tick, and `tc` follows it immediately.
- `count` digits are always valid BCD (0–9).

## Timing
- Reset values: `count`=16'h0000, `wrap`=0, `clk10Hz_d`=1.
  - Because `clk10Hz_d` resets to 1, a `clk10Hz` that is already high when reset releases does not produce a tick.
- Tick latency: the count updates at the first `clkFPGA` edge that samples `clk10Hz`=1 while `clk10Hz_d`=0. The new value is visible one cycle after `clk10Hz` rises.
- At most one step per `clk10Hz` period.
- `wrap` is registered and asserts in the same cycle the rolled-over `count` appears.
- `clr` and `load` take effect at the next clock edge (1-cycle latency).
- `rst` asserted mid-count forces the reset values immediately, without waiting for a clock edge.

## Configuration
- Macro `BCD_LOAD_EN`:
  - Defined: the `load`/`load_val` ports and the load path exist.
  - Undefined: those ports are absent, and priority reduces to `rst` > `clr` > step.

## Structure
- Shared package `bcd_pkg`:
  - `bcd_digit_t` (4-bit) and `bcd4_t` (16-bit packed) types.
  - Constants `BCD_MAX`=4'd9 and `BCD_ZERO`=4'd0.
- Sub-module `bcd_digit`: one decade with inputs `step`, `up`, `clr`, `ld`, `ld_val`, a 4-bit output, and carry/borrow out.
  - Instantiate four times; the carry/borrow chain is combinational.
  - Top level owns the edge detect, the `WRAP` policy and the `wrap` register.

## Test plan
- Reset with `clk10Hz` high -> `count`=0000, `wrap`=0, and no step after reset releases until `clk10Hz` falls and rises again.
- `en`=1, `up`=1, 12 `clk10Hz` periods from 0000 -> `count`=0012; exactly one step per period.
- Load 0998 (`BCD_LOAD_EN`), up, 2 ticks -> 0999 then 1000; then load 9999, 1 tick -> 0000 with a single-cycle `wrap`.
- `up`=0 from 0000, `WRAP`=1 -> 9999 with `wrap`=1; same stimulus with `WRAP`=0 -> holds at 0000, `wrap`=0, `tc`=1.
- `load_val`=16'hA3F5 -> `count`=9395; `clr` asserted together with a tick at 0500 -> 0000, not 0001.
- `en`=0 across 5 ticks at 0042 -> stays 0042; re-enable while `clk10Hz` is high -> no step until the next rising edge.
